// File: rtl/rlc_game_system_switches_poll_ctrl.sv
// Switches poller: periodically reads an 8-bit PIO, debounces it and exposes state/edge registers to the CPU.
// Define SWITCHES_POLL_IRQ_EN to add the irq mask register and the irq output.
module rlc_game_system_switches_poll_ctrl #(
    parameter int unsigned DEBOUNCE_CNT = 4,
    parameter logic [15:0] PERIOD_RST   = 16'd50000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [1:0]  m_address,
    output logic        m_read,
    input  logic        m_waitrequest,
    input  logic        m_readdatavalid,
    input  logic [31:0] m_readdata,
    input  logic [1:0]  s_address,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata
`ifdef SWITCHES_POLL_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam logic [3:0] DEB = 4'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, UPDATE} state_t;

    state_t      state, state_next;
    logic [15:0] timer, period;
    logic        enable;
    logic [7:0]  sample, candidate, debounced, edge_cap, mask;
    logic [3:0]  stable_cnt, cnt_next;
    logic [7:0]  cand_next, edge_set, edge_clr;
    logic        accept;
    logic [31:0] rd_mux;
    logic        unused_bits;

    assign unused_bits = ^{m_readdata[31:8], s_writedata[30:16]};
    assign m_address   = 2'b00;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (enable && timer == 16'd0) state_next = REQ;
            REQ:     if (!m_waitrequest)           state_next = WAIT;
            WAIT:    if (m_readdatavalid)          state_next = UPDATE;
            UPDATE:                                state_next = IDLE;
            default:                               state_next = IDLE;
        endcase
    end

    always_comb begin
        m_read = (state == REQ);
    end

    // Debounce step: a run of identical samples must reach DEB before it replaces the debounced value.
    always_comb begin
        cand_next = candidate;
        cnt_next  = stable_cnt;
        if (sample == candidate) begin
            if (stable_cnt < DEB) cnt_next = stable_cnt + 4'd1;
        end else begin
            cand_next = sample;
            cnt_next  = 4'd1;
        end
    end

    assign accept   = (cnt_next == DEB) && (cand_next != debounced);
    assign edge_set = (state == UPDATE && accept) ? (cand_next ^ debounced) : 8'd0;
    assign edge_clr = (s_write && s_address == 2'd2) ? s_writedata[7:0] : 8'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            timer      <= PERIOD_RST;
            period     <= PERIOD_RST;
            enable     <= 1'b1;
            sample     <= 8'd0;
            candidate  <= 8'd0;
            stable_cnt <= 4'd0;
            debounced  <= 8'd0;
            edge_cap   <= 8'd0;
        end else begin
            // Clear before set so a same-cycle capture survives a write-1-to-clear.
            edge_cap <= (edge_cap & ~edge_clr) | edge_set;
            if (s_write && s_address == 2'd1) begin
                period <= s_writedata[15:0];
                enable <= s_writedata[31];
            end
            case (state)
                IDLE:   if (enable && timer != 16'd0) timer <= timer - 16'd1;
                WAIT:   if (m_readdatavalid) sample <= m_readdata[7:0];
                UPDATE: begin
                    candidate  <= cand_next;
                    stable_cnt <= cnt_next;
                    if (accept) debounced <= cand_next;
                    timer <= (period == 16'd0) ? 16'd1 : period;
                end
                default: ;
            endcase
        end
    end

`ifdef SWITCHES_POLL_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            mask <= 8'd0;
            irq  <= 1'b0;
        end else begin
            if (s_write && s_address == 2'd3) mask <= s_writedata[7:0];
            irq <= |(edge_cap & mask);
        end
    end
`else
    assign mask = 8'd0;
`endif

    always_comb begin
        rd_mux = 32'd0;
        case (s_address)
            2'd0:    rd_mux = {24'd0, debounced};
            2'd1:    rd_mux = {enable, 15'd0, period};
            2'd2:    rd_mux = {24'd0, edge_cap};
            default: rd_mux = {24'd0, mask};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)       s_readdata <= 32'd0;
        else if (s_read) s_readdata <= rd_mux;
    end

endmodule
